// File: rtl/usb_tx_serializer_if.sv
// usb_tx_serializer_if: byte handshake, bit strobe and line-side outputs of the USB FS transmit serializer
//   bit_tick              bit-time strobe from the upstream clock recovery
//   in_byte/in_last       packet byte (LSB first) and end-of-packet qualifier
//   in_valid/in_ready     byte handshake; transfer when both are high
//   out_dp/out_dn/out_oe  line levels and drive enable
//   busy                  packet in progress
//   tx_underrun           one-cycle pulse when a non-last byte has no successor
//   one_count             current run of transmitted data 1s
interface usb_tx_serializer_if;
    logic       bit_tick;
    logic [7:0] in_byte;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       out_dp;
    logic       out_dn;
    logic       out_oe;
    logic       busy;
    logic       tx_underrun;
    logic [2:0] one_count;

    modport master (
        output bit_tick, in_byte, in_last, in_valid,
        input  in_ready, out_dp, out_dn, out_oe, busy, tx_underrun, one_count
    );

    modport slave (
        input  bit_tick, in_byte, in_last, in_valid,
        output in_ready, out_dp, out_dn, out_oe, busy, tx_underrun, one_count
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB FS transmit bit path -- byte holding register, LSB-first shifter,
// bit stuffing, NRZI encoding and SE0/J end-of-packet generation
//   clk   system clock
//   nRST  asynchronous active-low reset
//   bus   usb_tx_serializer_if.slave (handshake, bit_tick, line outputs, status)
module usb_tx_serializer #(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input logic                clk,
    input logic                nRST,
    usb_tx_serializer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    localparam logic [2:0] STUFF_N  = 3'(STUFF_LEN);
    localparam logic [7:0] EOP_LAST = 8'(EOP_SE0_BITS - 1);

    state_t     state_q;
    logic [7:0] hold_q, shift_q, eop_cnt_q;
    logic [2:0] bit_idx_q, one_cnt_q;
    logic       hold_full_q, hold_last_q, cur_last_q, last_taken_q;
    logic       lvl_q, dp_q, dn_q, oe_q, underrun_q;

    logic       take, bit_d, lvl_d, boundary;
    logic [2:0] ones_d;

    assign take   = bus.in_valid && bus.in_ready;
    assign bit_d  = shift_q[0];
    assign ones_d = bit_d ? one_cnt_q + 3'd1 : 3'd0;
    // NRZI: a 0 toggles the line, a 1 holds it; lvl_q=1 means J
    assign lvl_d  = bit_d ? lvl_q : ~lvl_q;
    // Byte boundary: bit 7 sent with no stuff owed, or the stuff bit that followed bit 7
    assign boundary = bus.bit_tick && bit_idx_q == 3'd7 &&
                      ((state_q == DATA && ones_d != STUFF_N) || state_q == STUFF);

    assign bus.in_ready    = !hold_full_q && !last_taken_q;
    assign bus.out_dp      = dp_q;
    assign bus.out_dn      = dn_q;
    assign bus.out_oe      = oe_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.tx_underrun = underrun_q;
    assign bus.one_count   = one_cnt_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            shift_q      <= 8'd0;
            eop_cnt_q    <= 8'd0;
            bit_idx_q    <= 3'd0;
            one_cnt_q    <= 3'd0;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            cur_last_q   <= 1'b0;
            last_taken_q <= 1'b0;
            lvl_q        <= 1'b1;
            dp_q         <= 1'b1;
            dn_q         <= 1'b0;
            oe_q         <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (take) begin
                hold_q      <= bus.in_byte;
                hold_full_q <= 1'b1;
                hold_last_q <= bus.in_last;
                if (bus.in_last) last_taken_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    {dp_q, dn_q, oe_q} <= 3'b100;
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        cur_last_q  <= hold_last_q;
                        hold_full_q <= 1'b0;
                        bit_idx_q   <= 3'd0;
                        one_cnt_q   <= 3'd0;
                        lvl_q       <= 1'b1;
                        state_q     <= DATA;
                    end
                end
                DATA: if (bus.bit_tick) begin
                    {dp_q, dn_q, oe_q} <= {lvl_d, ~lvl_d, 1'b1};
                    lvl_q              <= lvl_d;
                    one_cnt_q          <= ones_d;
                    if (ones_d == STUFF_N) begin
                        state_q <= STUFF;
                    end else if (bit_idx_q != 3'd7) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                STUFF: if (bus.bit_tick) begin
                    {dp_q, dn_q, oe_q} <= {~lvl_q, lvl_q, 1'b1};
                    lvl_q              <= ~lvl_q;
                    one_cnt_q          <= 3'd0;
                    if (bit_idx_q != 3'd7) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        state_q   <= DATA;
                    end
                end
                EOP_SE0: if (bus.bit_tick) begin
                    {dp_q, dn_q, oe_q} <= 3'b001;
                    if (eop_cnt_q == EOP_LAST) state_q <= EOP_J;
                    else eop_cnt_q <= eop_cnt_q + 8'd1;
                end
                EOP_J: if (bus.bit_tick) begin
                    {dp_q, dn_q, oe_q} <= 3'b101;
                    last_taken_q       <= 1'b0;
                    one_cnt_q          <= 3'd0;
                    state_q            <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Uses the pre-transfer hold state, so a byte taken on this very tick is not seen
            if (boundary) begin
                eop_cnt_q <= 8'd0;
                if (cur_last_q) begin
                    state_q <= EOP_SE0;
                end else if (hold_full_q) begin
                    shift_q     <= hold_q;
                    cur_last_q  <= hold_last_q;
                    hold_full_q <= 1'b0;
                    bit_idx_q   <= 3'd0;
                    state_q     <= DATA;
                end else begin
                    underrun_q <= 1'b1;
                    state_q    <= EOP_SE0;
                end
            end
        end
    end
endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
Transmit-side serializer for the USB full-speed bit path, the counterpart of the receive-side unstuffer. It accepts packet bytes over a valid/ready handshake and shifts them out LSB-first, one bit per bit_tick. It inserts a stuffed 0 after every STUFF_LEN consecutive 1s, NRZI-encodes the result onto dp/dn, and terminates each packet with SE0 x EOP_SE0_BITS followed by one J. Upstream supplies SYNC and PID as ordinary bytes.

Parameters:
STUFF_LEN, 6, number of consecutive 1s after which a 0 is stuffed (1..7).
EOP_SE0_BITS, 2, number of SE0 bit times in the EOP.

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
bit_tick  in  1  single-cycle strobe, one per bit time
in_byte  in  8  packet byte, LSB transmitted first
in_last  in  1  qualifies in_byte as the final byte of the packet
in_valid  in  1  in_byte/in_last valid
in_ready  out  1  holding register can accept a byte
out_dp  out  1  D+ line level
out_dn  out  1  D- line level
out_oe  out  1  transmitter drive enable
busy  out  1  packet in progress (not IDLE)
tx_underrun  out  1  one-cycle pulse: holding register empty at a byte boundary of a non-last byte
one_count  out  3  current run of consecutive transmitted data 1s

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is clk. All state is cleared immediately on reset, including mid-packet.
- Reset values: out_dp=1, out_dn=0 (J), out_oe=0, busy=0, tx_underrun=0, one_count=0, in_ready=1. Holding register is empty and state is IDLE.
- Storage is a one-byte holding register plus an 8-bit shifter.
- Transfer occurs when in_valid && in_ready.
- in_ready = hold_empty && !last_taken. last_taken sets when a byte with in_last=1 is accepted and clears on entry to IDLE.
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - Outputs J with out_oe=0.
  - When the holding register is full, load the shifter from it (hold becomes empty), set bit_idx=0 and one_count=0, preset the NRZI level to J, and go to DATA.
  - bit_tick is otherwise ignored.
- DATA, on bit_tick:
  - Drive bit b=shifter[0] via NRZI: b=0 toggles the level (J<->K), b=1 holds it. J is dp=1/dn=0; K is dp=0/dn=1. out_oe=1.
  - one_count updates to one_count+1 if b=1, else 0.
  - If the new one_count equals STUFF_LEN, go to STUFF after this bit.
  - Otherwise, if bit_idx==7, take the byte-boundary action; else shift and increment bit_idx.
- STUFF, on bit_tick:
  - Drive a 0 (toggle) and set one_count=0.
  - If the stuffed bit followed bit_idx 7, take the byte-boundary action; else shift, increment bit_idx, and return to DATA.
- Byte-boundary action, resolved in order:
  1. Current byte was last: go to EOP_SE0.
  2. Holding register full: load the shifter, set bit_idx=0, go to DATA. one_count carries across bytes.
  3. Otherwise: pulse tx_underrun for one cycle, then go to EOP_SE0.
- A stuff bit owed after the final data bit is always sent before EOP.
- EOP_SE0: dp=0, dn=0, oe=1 for EOP_SE0_BITS ticks, then EOP_J.
- EOP_J: drives J with oe=1 for one tick, then enters IDLE with oe=0 and one_count=0.
- Latency: outputs are registered and change in the cycle after the qualifying bit_tick. The first bit goes out on the first bit_tick after entering DATA.
- Simultaneous events:
  - A handshake transfer and a bit_tick in the same cycle are both honoured.
  - A byte accepted in the same cycle as the boundary tick is not seen by that boundary; the boundary uses the holding-register state before the transfer, so the result is underrun.
- bit_tick on consecutive cycles is legal.

Test Plan:
- Reset mid-packet (assert nRST during DATA) -> same cycle: dp=1, dn=0, oe=0, busy=0, one_count=0, in_ready=1.
- Single byte 0x80, in_last=1 -> line per tick: K J K J K J K K, SE0, SE0, J; then oe=0 and busy=0. in_ready stays 0 from acceptance until IDLE.
- Bytes 0xFF, 0xFF(last) ->
  - 18 data-phase ticks, with stuffed toggles after data bits 6 and 12.
  - one_count sequence 1..6,0,1..6,0,1..4.
  - Then EOP.
- Byte 0xFC, last (bits 0,0,1,1,1,1,1,1) -> K J J J J J J J, then a stuffed K, then SE0, SE0, J. Nine data-phase ticks.
- Byte 0x3F (not last), no second byte supplied ->
  - Stuff after bit 5, then bits 6 and 7.
  - At the boundary: tx_underrun pulses exactly 1 cycle, then SE0, SE0, J, then IDLE.
- Backpressure: hold in_valid high with three bytes -> in_ready toggles so each byte is accepted once, with no gaps in the tick stream. A new packet is accepted only after EOP_J completes.
